// File: rtl/gcm_ctr_feeder.sv
// gcm_ctr_feeder: AES-GCM counter-mode front end. Issues inc32 counter blocks, queues plaintext and
// sideband in order, and XORs returning keystream into masked ciphertext. J0 tagging: GCM_FEEDER_TAG_J0_EN.
module gcm_ctr_feeder #(
    parameter int BYPASS_W = 161,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_new,
    input  logic                   i_last,
    input  logic [95:0]            i_iv,
    input  logic [127:0]           i_plain_text,
    input  logic [BYPASS_W-1:0]    i_bypass_text,
    input  logic [3:0]             i_last_bytes,
    output logic                   o_ctr_valid,
    output logic [127:0]           o_ctr_block,
    output logic                   o_ctr_j0,
    input  logic                   i_ks_valid,
    input  logic [127:0]           i_ks,
    output logic                   o_valid,
    output logic [127:0]           o_cipher_text,
    output logic [BYPASS_W-1:0]    o_bypass_text,
    output logic                   o_new,
    output logic                   o_last,
    output logic                   o_ek_j0_valid,
    output logic [127:0]           o_ek_j0,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [1:0]             o_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef GCM_FEEDER_TAG_J0_EN
    localparam bit J0_EN = 1'b1;
`else
    localparam bit J0_EN = 1'b0;
`endif
    // A J0 token rides with the first block of a message, so keep room for two entries.
    localparam logic [CW-1:0] READY_MAX = CW'(J0_EN ? DEPTH - 2 : DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [127:0]        pt;
        logic [BYPASS_W-1:0] bypass;
        logic                is_new;
        logic                is_last;
        logic [3:0]          last_bytes;
        logic                j0;
    } entry_t;

    entry_t              mem_reg [DEPTH];
    state_t              state_reg, state_next;
    logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]       count_reg, count_next;
    logic                ready_reg, ready_next;
    logic [31:0]         ctr_reg, ctr_next;
    logic [95:0]         iv_reg, iv_next;
    logic                j0_pend_reg;
    logic                ctr_valid_reg, ctr_j0_reg;
    logic [127:0]        ctr_block_reg;
    logic                valid_reg, new_reg, last_reg;
    logic [127:0]        cipher_reg;
    logic [BYPASS_W-1:0] bypass_reg;
    logic                ek_valid_reg;
    logic [127:0]        ek_reg;
    logic [1:0]          err_reg;

    logic                accept, data_acc, orphan, j0_acc, pop;
    entry_t              data_entry, token_entry, head;
    logic [4:0]          keep_bytes;
    logic [127:0]        mask;

    always_comb begin
        accept      = i_valid && ready_reg;
        data_acc    = accept && (i_new || state_reg == RUN);
        orphan      = accept && !i_new && state_reg == IDLE;
        j0_acc      = J0_EN && data_acc && i_new;
        pop         = i_ks_valid && count_reg != '0;
        state_next  = state_reg;
        if (data_acc)
            state_next = i_last ? IDLE : RUN;
        count_next  = count_reg;
        if (data_acc)
            count_next = count_next + CW'(1);
        if (j0_acc)
            count_next = count_next + CW'(1);
        if (pop)
            count_next = count_next - CW'(1);
        ready_next  = count_next <= READY_MAX && !j0_acc;
        ctr_next    = i_new ? 32'd2 : ctr_reg + 32'd1;
        iv_next     = i_new ? i_iv : iv_reg;
        data_entry  = '{pt: i_plain_text, bypass: i_bypass_text, is_new: i_new, is_last: i_last,
                        last_bytes: i_last_bytes, j0: 1'b0};
        token_entry = '0;
        token_entry.j0 = 1'b1;
        head        = mem_reg[rd_ptr_reg];
        // Only a last block is trimmed; a byte count of 0 means a full block.
        keep_bytes  = (head.is_last && head.last_bytes != 4'd0) ? {1'b0, head.last_bytes} : 5'd16;
        mask        = {128{1'b1}} << ({3'b000, 5'd16 - keep_bytes} << 3);
    end

    always_ff @(posedge clk) begin
        if (data_acc)
            mem_reg[wr_ptr_reg] <= j0_acc ? token_entry : data_entry;
        if (j0_acc)
            mem_reg[wr_ptr_reg + AW'(1)] <= data_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            ready_reg     <= 1'b0;
            ctr_reg       <= '0;
            iv_reg        <= '0;
            j0_pend_reg   <= 1'b0;
            ctr_valid_reg <= 1'b0;
            ctr_j0_reg    <= 1'b0;
            ctr_block_reg <= '0;
            valid_reg     <= 1'b0;
            new_reg       <= 1'b0;
            last_reg      <= 1'b0;
            cipher_reg    <= '0;
            bypass_reg    <= '0;
            ek_valid_reg  <= 1'b0;
            ek_reg        <= '0;
            err_reg       <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            ready_reg  <= ready_next;
            wr_ptr_reg <= wr_ptr_reg + (j0_acc ? AW'(2) : (data_acc ? AW'(1) : AW'(0)));
            if (data_acc) begin
                ctr_reg <= ctr_next;
                iv_reg  <= iv_next;
            end
            // The data counter of a tagged message trails its J0 request by one cycle.
            if (j0_acc) begin
                ctr_valid_reg <= 1'b1;
                ctr_block_reg <= {i_iv, 32'd1};
                ctr_j0_reg    <= 1'b1;
                j0_pend_reg   <= 1'b1;
            end else if (data_acc) begin
                ctr_valid_reg <= 1'b1;
                ctr_block_reg <= {iv_next, ctr_next};
                ctr_j0_reg    <= 1'b0;
            end else if (j0_pend_reg) begin
                ctr_valid_reg <= 1'b1;
                ctr_block_reg <= {iv_reg, 32'd2};
                ctr_j0_reg    <= 1'b0;
                j0_pend_reg   <= 1'b0;
            end else begin
                ctr_valid_reg <= 1'b0;
                ctr_j0_reg    <= 1'b0;
            end
            valid_reg    <= 1'b0;
            ek_valid_reg <= 1'b0;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                if (J0_EN && head.j0) begin
                    ek_valid_reg <= 1'b1;
                    ek_reg       <= i_ks;
                end else begin
                    valid_reg  <= 1'b1;
                    cipher_reg <= (head.pt ^ i_ks) & mask;
                    bypass_reg <= head.bypass;
                    new_reg    <= head.is_new;
                    last_reg   <= head.is_last;
                end
            end
            if (i_ks_valid && count_reg == '0)
                err_reg[0] <= 1'b1;
            if (orphan)
                err_reg[1] <= 1'b1;
        end
    end

    assign o_ready       = ready_reg;
    assign o_count       = count_reg;
    assign o_err         = err_reg;
    assign o_ctr_valid   = ctr_valid_reg;
    assign o_ctr_block   = ctr_block_reg;
    assign o_ctr_j0      = ctr_j0_reg;
    assign o_valid       = valid_reg;
    assign o_cipher_text = cipher_reg;
    assign o_bypass_text = bypass_reg;
    assign o_new         = new_reg;
    assign o_last        = last_reg;
    assign o_ek_j0_valid = ek_valid_reg;
    assign o_ek_j0       = ek_reg;
endmodule

// File: tb/tb_gcm_ctr_feeder.sv
// Bench for gcm_ctr_feeder: queue-based reference model compared every cycle, directed literal
// checks for the worked examples, then randomized traffic.
module tb_gcm_ctr_feeder;
    localparam int BW    = 161;
    localparam int DEPTH = 8;
`ifdef GCM_FEEDER_TAG_J0_EN
    localparam int FULL_LVL = DEPTH - 1;
    localparam int RDY_MAX  = DEPTH - 2;
`else
    localparam int FULL_LVL = DEPTH;
    localparam int RDY_MAX  = DEPTH - 1;
`endif
    localparam logic [95:0]  IV1 = 96'hCAFEBABEFACEDBADDECAF888;
    localparam logic [127:0] PT1 = 128'hD9313225F88406E5A55909C5AFF5269A;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic clk = 1'b0, reset_n = 1'b0;
    logic i_valid = 0, i_new = 0, i_last = 0, i_ks_valid = 0;
    logic [95:0] i_iv = '0;
    logic [127:0] i_plain_text = '0, i_ks = '0;
    logic [BW-1:0] i_bypass_text = '0;
    logic [3:0] i_last_bytes = '0;
    logic o_ready, o_ctr_valid, o_ctr_j0, o_valid, o_new, o_last, o_ek_j0_valid;
    logic [127:0] o_ctr_block, o_cipher_text, o_ek_j0;
    logic [BW-1:0] o_bypass_text;
    logic [$clog2(DEPTH):0] o_count;
    logic [1:0] o_err;

    gcm_ctr_feeder #(.BYPASS_W(BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready), .i_new(i_new),
        .i_last(i_last), .i_iv(i_iv), .i_plain_text(i_plain_text), .i_bypass_text(i_bypass_text),
        .i_last_bytes(i_last_bytes), .o_ctr_valid(o_ctr_valid), .o_ctr_block(o_ctr_block),
        .o_ctr_j0(o_ctr_j0), .i_ks_valid(i_ks_valid), .i_ks(i_ks), .o_valid(o_valid),
        .o_cipher_text(o_cipher_text), .o_bypass_text(o_bypass_text), .o_new(o_new),
        .o_last(o_last), .o_ek_j0_valid(o_ek_j0_valid), .o_ek_j0(o_ek_j0), .o_count(o_count),
        .o_err(o_err)
    );

    initial forever #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [127:0] pt;
        logic [BW-1:0] byp;
        bit nw, lst, j0;
        logic [3:0] lb;
    } ent_t;

    ent_t m_q[$];
    bit m_open = 0, m_pend = 0;
    logic [31:0] m_ctr = '0;
    logic [95:0] m_iv = '0;
    int wrap_req = 0, wrap_seen = 0;
    logic e_ready = 0, e_cv = 0, e_cj0 = 0, e_v = 0, e_new = 0, e_last = 0, e_ekv = 0;
    logic [127:0] e_cb = '0, e_ct = '0, e_ek = '0;
    logic [BW-1:0] e_bp = '0;
    logic [1:0] e_err = '0;
    int e_count = 0;

    function automatic logic [127:0] mask_of(input bit lst, input logic [3:0] lb);
        int n;
        logic [127:0] m;
        n = (lst && lb != 0) ? int'(lb) : 16;
        m = '0;
        for (int b = 0; b < 16; b++)
            if (b < n) m[127 - 8*b -: 8] = 8'hFF;
        return m;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete(); m_open = 0; m_pend = 0; m_ctr = '0; m_iv = '0;
            e_ready = 0; e_cv = 0; e_cj0 = 0; e_v = 0; e_new = 0; e_last = 0; e_ekv = 0;
            e_cb = '0; e_ct = '0; e_ek = '0; e_bp = '0; e_err = '0; e_count = 0;
        end else begin
            ent_t ent;
            e_cv = 0; e_cj0 = 0; e_v = 0; e_ekv = 0;
            if (wrap_req != wrap_seen) begin m_ctr = 32'hFFFF_FFFF; wrap_seen = wrap_req; end
            if (i_ks_valid) begin
                if (m_q.size() == 0) e_err[0] = 1'b1;
                else begin
                    ent = m_q.pop_front();
                    if (ent.j0) begin e_ekv = 1; e_ek = i_ks; end
                    else begin
                        e_v = 1; e_ct = (ent.pt ^ i_ks) & mask_of(ent.lst, ent.lb);
                        e_bp = ent.byp; e_new = ent.nw; e_last = ent.lst;
                    end
                end
            end
            if (m_pend) begin e_cv = 1; e_cb = {m_iv, 32'd2}; m_pend = 0; end
            if (i_valid && e_ready) begin
                ent = '{pt: i_plain_text, byp: i_bypass_text, nw: i_new, lst: i_last, j0: 0, lb: i_last_bytes};
                if (i_new) begin
                    m_iv = i_iv; m_ctr = 32'd2; m_open = !i_last;
`ifdef GCM_FEEDER_TAG_J0_EN
                    m_q.push_back('{pt: '0, byp: '0, nw: 0, lst: 0, j0: 1, lb: '0});
                    e_cv = 1; e_cj0 = 1; e_cb = {i_iv, 32'd1}; m_pend = 1;
`else
                    e_cv = 1; e_cb = {i_iv, 32'd2};
`endif
                    m_q.push_back(ent);
                end else if (m_open) begin
                    m_ctr = m_ctr + 32'd1; m_open = !i_last;
                    e_cv = 1; e_cb = {m_iv, m_ctr};
                    m_q.push_back(ent);
                end else e_err[1] = 1'b1;
            end
            e_count = m_q.size();
            e_ready = (m_q.size() <= RDY_MAX) && !m_pend;
        end
    end

    // ---------------- checking ----------------
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_all();
        chk("ready", o_ready, e_ready);
        chk("count", o_count, e_count);
        chk("err", o_err, e_err);
        chk("ctr_valid", o_ctr_valid, e_cv);
        chk("ctr_j0", o_ctr_j0, e_cj0);
        chk("valid", o_valid, e_v);
        chk("ek_valid", o_ek_j0_valid, e_ekv);
        if (e_cv) chk("ctr_block", o_ctr_block, e_cb);
        if (e_v) begin
            chk("cipher", o_cipher_text, e_ct);
            chk("bypass", o_bypass_text, e_bp);
            chk("framing", {o_new, o_last}, {e_new, e_last});
        end
        if (e_ekv) chk("ek_j0", o_ek_j0, e_ek);
    endtask

    task automatic cycle();
        @(negedge clk);
        cmp_all();
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [BW-1:0] randbp();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[BW-1:0];
    endfunction

    task automatic send_block(input bit nw, input bit lst, input logic [95:0] iv,
                              input logic [127:0] pt, input logic [BW-1:0] bp, input logic [3:0] lb);
        int n;
        n = 0;
        i_valid = 1; i_new = nw; i_last = lst; i_iv = iv;
        i_plain_text = pt; i_bypass_text = bp; i_last_bytes = lb;
        while (!o_ready && n < 100) begin cycle(); n++; end
        if (!o_ready) chk("send_timeout", o_ready, 1);
        cycle();
        i_valid = 0; i_new = 0; i_last = 0;
    endtask

    task automatic send_ks(input logic [127:0] ks);
        i_ks_valid = 1; i_ks = ks;
        cycle();
        i_ks_valid = 0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (m_q.size() != 0 && g < 4 * DEPTH) begin send_ks(rand128()); g++; end
        chk("drain_count", o_count, 0);
    endtask

    logic [BW-1:0] byp1;
    logic [95:0] iv2;

    initial begin
        repeat (3) cycle();
        reset_n = 1;
        cycle();
        chk("ready_after_reset", o_ready, 1);

        // single-block message
        byp1 = randbp();
        send_block(1, 1, IV1, PT1, byp1, 4'd0);
`ifdef GCM_FEEDER_TAG_J0_EN
        chk("j0_req", {o_ctr_j0, o_ctr_block}, {1'b1, IV1, 32'd1});
        cycle();
`endif
        chk("t1_ctr", o_ctr_block, {IV1, 32'd2});
`ifdef GCM_FEEDER_TAG_J0_EN
        send_ks(128'h0123456789ABCDEF0F1E2D3C4B5A6978);
        chk("t1_ek", {o_ek_j0_valid, o_ek_j0}, {1'b1, 128'h0123456789ABCDEF0F1E2D3C4B5A6978});
`endif
        send_ks(ONES);
        chk("t1_cipher", o_cipher_text, 128'h26CECDDA077BF91A5AA6F63A500AD965);
        chk("t1_bypass", o_bypass_text, byp1);
        chk("t1_framing", {o_valid, o_new, o_last}, 3'b111);

        // partial last block
        send_block(1, 1, IV1, PT1, randbp(), 4'd3);
`ifdef GCM_FEEDER_TAG_J0_EN
        send_ks(rand128());
`endif
        send_ks(ONES);
        chk("t2_cipher", o_cipher_text, 128'h26CECD00000000000000000000000000);

        // three blocks back to back
        iv2 = {$urandom(), $urandom(), $urandom()};
        send_block(1, 0, iv2, rand128(), randbp(), 4'd0);
`ifndef GCM_FEEDER_TAG_J0_EN
        chk("t3_ctr0", o_ctr_block[31:0], 32'd2);
`endif
        send_block(0, 0, iv2, rand128(), randbp(), 4'd0);
        chk("t3_ctr1", o_ctr_block[31:0], 32'd3);
        send_block(0, 1, iv2, rand128(), randbp(), 4'd7);
        chk("t3_ctr2", o_ctr_block, {iv2, 32'd4});
        repeat (5) cycle();
`ifdef GCM_FEEDER_TAG_J0_EN
        send_ks(rand128());
`endif
        send_ks(rand128());
        send_ks(rand128());
        send_ks(rand128());
        chk("t3_last", {o_valid, o_last}, 2'b11);

        // backpressure
        iv2 = {$urandom(), $urandom(), $urandom()};
        i_valid = 1; i_new = 1; i_last = 0; i_iv = iv2; i_last_bytes = 0;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            i_plain_text = rand128(); i_bypass_text = randbp();
            cycle();
            i_new = 0;
        end
        i_valid = 0;
        chk("bp_full_count", o_count, FULL_LVL);
        chk("bp_full_ready", o_ready, 0);
        send_ks(rand128());
        chk("bp_ready_back", o_ready, 1);
        drain();

        // counter wrap: message from the backpressure step is still open
        force dut.ctr_reg = 32'hFFFF_FFFF;
        wrap_req++;
        #1 release dut.ctr_reg;
        send_block(0, 1, 96'h0, rand128(), randbp(), 4'd0);
        chk("wrap_ctr", o_ctr_block, {iv2, 32'h0000_0000});
        drain();

        // orphan block, then keystream on empty FIFO
        chk("err_clear", o_err, 2'b00);
        send_block(0, 0, 96'h0, rand128(), randbp(), 4'd0);
        send_ks(rand128());
        chk("err_both", o_err, 2'b11);

        // reset mid-stream
        send_block(1, 0, iv2, rand128(), randbp(), 4'd0);
        send_block(0, 0, iv2, rand128(), randbp(), 4'd0);
        reset_n = 0;
        #1;
        chk("rst_ready", o_ready, 0);
        chk("rst_count", o_count, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ctr", {o_ctr_valid, o_ctr_j0, o_ctr_block}, 0);
        chk("rst_out", {o_valid, o_new, o_last, o_cipher_text}, 0);
        chk("rst_bypass", o_bypass_text, 0);
        chk("rst_ek", {o_ek_j0_valid, o_ek_j0}, 0);
        cycle();
        reset_n = 1;
        cycle();
        chk("rst_ready_rise", o_ready, 1);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            i_valid = ($urandom % 4) != 0;
            i_new = ($urandom % 6) == 0;
            i_last = ($urandom % 4) == 0;
            i_iv = {$urandom(), $urandom(), $urandom()};
            i_plain_text = rand128(); i_bypass_text = randbp();
            i_last_bytes = 4'($urandom % 16);
            i_ks_valid = ($urandom % 3) != 0;
            i_ks = rand128();
            cycle();
        end
        i_valid = 0; i_ks_valid = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
